// File: rtl/pc_sched.sv
// Next-PC scheduler for the fetch-stage PC register: selects sequential, branch/jump,
// exception or ERET targets and holds a redirect that resolves while fetch is stalled.
module pc_sched #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_f,
    input  logic             stall_f,
    input  logic             br_take_d,
    input  logic [WIDTH-1:0] br_target_d,
    input  logic             jump_d,
    input  logic [WIDTH-1:0] jump_target_d,
    input  logic             exc_req_m,
    input  logic             eret_m,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc_d,
    output logic             pc_en,
    output logic             pc_clear,
    output logic [WIDTH-1:0] new_pc,
    output logic             flush_fd,
    output logic             redirect_pend
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        EXC  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] pend_tgt;
    logic             pend_load;
    logic             redirect;
    logic [WIDTH-1:0] redirect_tgt;
    logic [WIDTH-1:0] seq_pc;

    assign seq_pc       = pc_f + WIDTH'(4);
    assign redirect     = jump_d | br_take_d;
    // Jump wins over branch when both are asserted in the same cycle.
    assign redirect_tgt = jump_d ? jump_target_d : br_target_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pend_tgt <= '0;
        end else begin
            state <= state_n;
            if (pend_load) begin
                pend_tgt <= redirect_tgt;
            end
        end
    end

    always_comb begin
        state_n       = state;
        pc_d          = seq_pc;
        pc_en         = ~stall_f;
        pc_clear      = 1'b0;
        flush_fd      = 1'b0;
        redirect_pend = (state == PEND);
        pend_load     = 1'b0;

        if (exc_req_m) begin
            // Leaving PEND here drops the held target.
            pc_d     = WIDTH'(EXC_VEC);
            pc_en    = 1'b0;
            pc_clear = 1'b1;
            flush_fd = 1'b1;
            state_n  = EXC;
        end else if (eret_m) begin
            pc_d     = epc;
            pc_en    = 1'b0;
            pc_clear = 1'b1;
            flush_fd = 1'b1;
            state_n  = EXC;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        pc_d = redirect_tgt;
                        if (stall_f) begin
                            pc_en     = 1'b0;
                            pend_load = 1'b1;
                            state_n   = PEND;
                        end else begin
                            pc_en = 1'b1;
                        end
                    end
                end
                PEND: begin
                    // D still holds the same branch, so its inputs are not re-sampled.
                    pc_d  = pend_tgt;
                    pc_en = ~stall_f;
                    if (!stall_f) begin
                        state_n = RUN;
                    end
                end
                EXC: begin
                    state_n = RUN;
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end

        if (rst) begin
            state_n       = RUN;
            pc_d          = WIDTH'(RESET_VEC);
            pc_en         = 1'b0;
            pc_clear      = 1'b0;
            flush_fd      = 1'b0;
            redirect_pend = 1'b0;
            pend_load     = 1'b0;
        end
    end

    // new_pc carries the clear target; pc_d already holds it in those cycles.
    assign new_pc = pc_d;

endmodule

// File: tb/tb_pc_sched.sv
// Directed bench for pc_sched: the driver pushes hand-computed expectations into a queue,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sched;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        stall_f;
    logic        br_take_d;
    logic [31:0] br_target_d;
    logic        jump_d;
    logic [31:0] jump_target_d;
    logic        exc_req_m;
    logic        eret_m;
    logic [31:0] epc;
    logic [31:0] pc_d;
    logic        pc_en;
    logic        pc_clear;
    logic [31:0] new_pc;
    logic        flush_fd;
    logic        redirect_pend;

    // {ignore_pc_d, pc_d[31:0], new_pc[31:0], pc_en, pc_clear, flush_fd, redirect_pend}
    logic [68:0] exp_q[$];
    string       name_q[$];
    int          n_checks;
    int          n_fail;

    pc_sched dut (
        .clk           (clk),
        .rst           (rst),
        .pc_f          (pc_f),
        .stall_f       (stall_f),
        .br_take_d     (br_take_d),
        .br_target_d   (br_target_d),
        .jump_d        (jump_d),
        .jump_target_d (jump_target_d),
        .exc_req_m     (exc_req_m),
        .eret_m        (eret_m),
        .epc           (epc),
        .pc_d          (pc_d),
        .pc_en         (pc_en),
        .pc_clear      (pc_clear),
        .new_pc        (new_pc),
        .flush_fd      (flush_fd),
        .redirect_pend (redirect_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector just after a rising edge and queue its expected outputs.
    // e_pc is the expected new_pc; pc_d is also checked against it unless pc_clear is expected.
    task automatic drive(input string nm, input logic r, input logic [31:0] pcf,
                         input logic st, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic ex,
                         input logic er, input logic [31:0] ep,
                         input logic [31:0] e_pc, input logic [3:0] e_fl);
        @(posedge clk);
        #1;
        rst           = r;
        pc_f          = pcf;
        stall_f       = st;
        br_take_d     = br;
        br_target_d   = bt;
        jump_d        = j;
        jump_target_d = jt;
        exc_req_m     = ex;
        eret_m        = er;
        epc           = ep;
        exp_q.push_back({e_fl[2], e_pc, e_pc, e_fl});
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        logic [68:0] exp_v;
        logic [67:0] act_v;
        string       nm;
        logic        bad;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {pc_d, new_pc, pc_en, pc_clear, flush_fd, redirect_pend};
            n_checks++;
            if (exp_v[68]) bad = (act_v[35:0] !== exp_v[35:0]);
            else           bad = (act_v !== exp_v[67:0]);
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got pc_d=%h new_pc=%h en/clr/flush/pend=%b, want pc_d=%h new_pc=%h en/clr/flush/pend=%b",
                         nm, act_v[67:36], act_v[35:4], act_v[3:0],
                         exp_v[67:36], exp_v[35:4], exp_v[3:0]);
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        pc_f          = '0;
        stall_f       = 1'b0;
        br_take_d     = 1'b0;
        br_target_d   = '0;
        jump_d        = 1'b0;
        jump_target_d = '0;
        exc_req_m     = 1'b0;
        eret_m        = 1'b0;
        epc           = '0;

        //    name            rst pc_f          st br bt            j  jt            ex er epc           exp_pc        en/clr/fl/pd
        drive("reset",        1, 32'h00000000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00000, 4'b0000);
        drive("seq0",         0, 32'hBFC00000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00004, 4'b1000);
        drive("seq1",         0, 32'hBFC00004, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00008, 4'b1000);
        drive("seq2",         0, 32'hBFC00008, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC0000C, 4'b1000);
        drive("seq_stall",    0, 32'hBFC0000C, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00010, 4'b0000);
        drive("seq_resume",   0, 32'hBFC0000C, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00010, 4'b1000);
        // Branch resolves under a 3-cycle stall, then releases the held target.
        drive("br_stall_run", 0, 32'hBFC00010, 1, 1, 32'hBFC00100, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00100, 4'b0000);
        drive("pend_hold1",   0, 32'hBFC00010, 1, 1, 32'hBFC00100, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00100, 4'b0001);
        drive("pend_hold2",   0, 32'hBFC00010, 1, 1, 32'hBFC00100, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00100, 4'b0001);
        drive("pend_release", 0, 32'hBFC00010, 0, 1, 32'hBFC00100, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00100, 4'b1001);
        drive("after_release",0, 32'hBFC00100, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00104, 4'b1000);
        drive("jump_over_br", 0, 32'hBFC00104, 0, 1, 32'hBFC00200, 1, 32'hBFC00300, 0, 0, 32'h0,        32'hBFC00300, 4'b1000);
        drive("br_no_stall",  0, 32'hBFC00300, 0, 1, 32'hBFC00400, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00400, 4'b1000);
        // Exception arrives while a jump is pending under stall.
        drive("jump_stall",   0, 32'hBFC00400, 1, 0, 32'h0,        1, 32'hBFC00500, 0, 0, 32'h0,        32'hBFC00500, 4'b0000);
        drive("exc_in_pend",  0, 32'hBFC00400, 1, 0, 32'h0,        1, 32'hBFC00500, 1, 0, 32'h0,        32'hBFC00380, 4'b0111);
        drive("exc_after",    0, 32'hBFC00380, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00384, 4'b1000);
        drive("eret",         0, 32'hBFC00384, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h80001234, 32'h80001234, 4'b0110);
        drive("eret_br_mask", 0, 32'h80001234, 0, 1, 32'hBFC00700, 0, 32'h0,        0, 0, 32'h0,        32'h80001238, 4'b1000);
        drive("exc_eret_jmp", 0, 32'h80001238, 0, 0, 32'h0,        1, 32'hBFC00900, 1, 1, 32'h80001234, 32'hBFC00380, 4'b0110);
        drive("exc_b2b",      0, 32'hBFC00380, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'hBFC00380, 4'b0110);
        drive("exc_mask_st",  0, 32'hBFC00380, 1, 1, 32'hBFC00800, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00384, 4'b0000);
        drive("wrap",         0, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00000000, 4'b1000);
        // Reset while a redirect is held: outputs go to reset values at once.
        drive("jump_stall2",  0, 32'h00000000, 1, 0, 32'h0,        1, 32'h00000040, 0, 0, 32'h0,        32'h00000040, 4'b0000);
        drive("pend_before",  0, 32'h00000000, 1, 0, 32'h0,        1, 32'h00000040, 0, 0, 32'h0,        32'h00000040, 4'b0001);
        drive("rst_mid_pend", 1, 32'h00000000, 1, 0, 32'h0,        1, 32'h00000040, 0, 0, 32'h0,        32'hBFC00000, 4'b0000);
        drive("post_rst",     0, 32'hBFC00000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hBFC00004, 4'b1000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
